// File: rtl/sprite_blitter.sv
// sprite_blitter: streams one SPR_W x SPR_H sprite from a registered ROM into
// the vga_adapter plot port, one pixel per cycle, skipping the colour-key and
// off-screen pixels, and finishing with a one-cycle done pulse.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; origin and ROM base latched on acceptance
//   S_RUN   | issuing ROM addresses, pipeline capturing pixel coordinates
//   S_FLUSH | last pixel draining through the output stage, then done
//
// Pipeline for pixel k: address issued at edge E(k), ROM data and coordinates
// meet at edge E(k+1), plot outputs registered at edge E(k+2).

module sprite_blitter #(
    parameter int          SPR_W       = 16,
    parameter int          SPR_H       = 16,
    parameter int          ADDR_W      = 10,
    parameter logic [7:0]  TRANSPARENT = 8'hE3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        originX,
    input  logic [6:0]        originY,
    input  logic [ADDR_W-1:0] spriteBase,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [7:0]        romData,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [7:0]        colour,
    output logic              writeEn,
    output logic              busy,
    output logic              done
);

    localparam int CX_W = 8;
    localparam int CY_W = 7;
    localparam logic [CX_W-1:0] LAST_CX = CX_W'(SPR_W - 1);
    localparam logic [CY_W-1:0] LAST_CY = CY_W'(SPR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        ox_q, ox_d;
    logic [6:0]        oy_q, oy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CX_W-1:0]   cx_q, cx_d;
    logic [CY_W-1:0]   cy_q, cy_d;
    logic [CX_W-1:0]   p_cx_q, p_cx_d;
    logic [CY_W-1:0]   p_cy_q, p_cy_d;
    logic              p_valid_q, p_valid_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [7:0]        colour_q, colour_d;
    logic              wen_q, wen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Screen coordinates are summed one bit wider so that clipping never wraps.
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       visible;

    // Output-stage pixel test: colour key plus right/bottom screen edges.
    always_comb begin
        sum_x   = {1'b0, ox_q} + {1'b0, p_cx_q};
        sum_y   = {1'b0, oy_q} + {1'b0, p_cy_q};
        visible = (romData != TRANSPARENT) && (sum_x < 9'd160) && (sum_y < 8'd120);
    end

    // Next-state logic for the sequencer, address generator and output stage.
    always_comb begin
        state_d   = state_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        addr_d    = addr_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        p_cx_d    = p_cx_q;
        p_cy_d    = p_cy_q;
        p_valid_d = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        wen_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Skipped pixels still consume their cycle; plot outputs just hold.
        if (p_valid_q && visible) begin
            x_d      = sum_x[7:0];
            y_d      = sum_y[6:0];
            colour_d = romData;
            wen_d    = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ox_d    = originX;
                    oy_d    = originY;
                    addr_d  = spriteBase;
                    cx_d    = '0;
                    cy_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                p_valid_d = 1'b1;
                p_cx_d    = cx_q;
                p_cy_d    = cy_q;
                if (cx_q == LAST_CX && cy_q == LAST_CY) begin
                    state_d = S_FLUSH;
                end else begin
                    // Row-major layout makes the linear index a plain increment.
                    addr_d = addr_q + ADDR_W'(1);
                    if (cx_q == LAST_CX) begin
                        cx_d = '0;
                        cy_d = cy_q + CY_W'(1);
                    end else begin
                        cx_d = cx_q + CX_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                // First FLUSH edge writes the last pixel; the second ends the blit.
                if (!p_valid_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    wen_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any blit in progress.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ox_q      <= '0;
            oy_q      <= '0;
            addr_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            p_cx_q    <= '0;
            p_cy_q    <= '0;
            p_valid_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            wen_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            addr_q    <= addr_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            p_cx_q    <= p_cx_d;
            p_cy_q    <= p_cy_d;
            p_valid_q <= p_valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            wen_q     <= wen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign romAddr = addr_q;
    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign writeEn = wen_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter with a 4x4 sprite and a registered ROM.
module tb_sprite_blitter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    originX = '0;
    logic [6:0]    originY = '0;
    logic [AW-1:0] spriteBase = '0;
    logic [AW-1:0] romAddr;
    logic [7:0]    romData = '0;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [7:0]    colour;
    logic          writeEn;
    logic          busy;
    logic          done;

    sprite_blitter #(.SPR_W(4), .SPR_H(4), .ADDR_W(AW), .TRANSPARENT(8'hE3)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .originX(originX), .originY(originY), .spriteBase(spriteBase),
        .romAddr(romAddr), .romData(romData),
        .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [1024];
    always @(posedge clk) romData <= rom[romAddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   wr_count = 0;

    // Monitor: every plot strobe must match the next expected pixel.
    always @(negedge clk) begin
        if (writeEn) begin
            pix_t e;
            wr_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected got (%0d,%0d,%h) expected none", x, y, colour);
            end else begin
                e = exp_q.pop_front();
                if (x !== e.x || y !== e.y || colour !== e.c) begin
                    fails++;
                    $display("FAIL write_pixel got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                             x, y, colour, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push_pix(input int px, input int py, input logic [7:0] c);
        pix_t p;
        p.x = 8'(px);
        p.y = 7'(py);
        p.c = c;
        exp_q.push_back(p);
    endtask

    // Expected writes for a full 4x4 blit from the bench's own ROM image.
    task automatic push_sprite(input int ox, input int oy, input int base);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (rom[base + r*4 + c] != 8'hE3 && ox + c < 160 && oy + r < 120)
                    push_pix(ox + c, oy + r, rom[base + r*4 + c]);
    endtask

    task automatic start_blit(input int ox, input int oy, input int base, output int s);
        @(negedge clk);
        originX    = 8'(ox);
        originY    = 7'(oy);
        spriteBase = AW'(base);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s     = cyc;
    endtask

    task automatic wait_done(input string name, input int s);
        bit seen = 0;
        bit busy_ok = 1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        check({name, "_done_seen"}, int'(seen), 1);
        if (seen) begin
            check({name, "_latency"}, cyc - s, 18);
            check({name, "_busy_during"}, int'(busy_ok), 1);
            check({name, "_busy_at_done"}, int'(busy), 0);
        end
    endtask

    int s, s2;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_writeEn", int'(writeEn), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_romAddr", int'(romAddr), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // T1: solid sprite, all 16 pixels written in row-major order
        for (int i = 0; i < 16; i++) rom[i] = 8'h1C;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) push_pix(10 + c, 20 + r, 8'h1C);
        wr_count = 0;
        start_blit(10, 20, 0, s);
        check("t1_busy_after_start", int'(busy), 1);
        wait_done("t1", s);
        check("t1_writes", wr_count, 16);
        check("t1_queue_left", exp_q.size(), 0);

        // T2: checkerboard of key and 8'h03, only 8 pixels drawn
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) rom[200 + r*4 + c] = ((r + c) % 2 == 0) ? 8'hE3 : 8'h03;
        push_sprite(40, 50, 200);
        wr_count = 0;
        start_blit(40, 50, 200, s);
        wait_done("t2", s);
        check("t2_writes", wr_count, 8);
        check("t2_queue_left", exp_q.size(), 0);

        // T3: bottom-right corner clip, 4 writes only
        push_pix(158, 118, 8'h1C); push_pix(159, 118, 8'h1C);
        push_pix(158, 119, 8'h1C); push_pix(159, 119, 8'h1C);
        wr_count = 0;
        start_blit(158, 118, 0, s);
        wait_done("t3", s);
        check("t3_writes", wr_count, 4);
        check("t3_queue_left", exp_q.size(), 0);

        // T4: fully off-screen
        wr_count = 0;
        start_blit(200, 5, 0, s);
        wait_done("t4", s);
        check("t4_writes", wr_count, 0);

        // T5: start mid-blit and on the done edge ignored; next cycle accepted
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) push_pix(30 + c, 40 + r, 8'h1C);
        wr_count = 0;
        start_blit(30, 40, 0, s);
        repeat (6) @(negedge clk);
        start   = 1'b1;
        originX = 8'd99;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        start   = 1'b1;
        originX = 8'd50;
        originY = 7'd60;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) push_pix(50 + c, 60 + r, 8'h1C);
        @(negedge clk);
        check("t5_first_done", int'(done), 1);
        check("t5_first_latency", cyc - s, 18);
        @(posedge clk);
        #1;
        start = 1'b0;
        s2    = cyc;
        check("t5_second_start_gap", s2 - s, 19);
        wait_done("t5b", s2);
        check("t5_writes", wr_count, 32);
        check("t5_queue_left", exp_q.size(), 0);

        // T6: reset while pixel 7 is in flight, then a clean full blit
        for (int i = 0; i < 16; i++) rom[100 + i] = 8'h40 + 8'(i);
        for (int i = 0; i < 7; i++) push_pix(10 + i % 4, 20 + i / 4, 8'h40 + 8'(i));
        wr_count = 0;
        start_blit(10, 20, 100, s);
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("t6_writeEn", int'(writeEn), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_done", int'(done), 0);
        check("t6_romAddr", int'(romAddr), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_partial_writes", wr_count, 7);
        check("t6_queue_left", exp_q.size(), 0);
        push_sprite(10, 20, 100);
        wr_count = 0;
        start_blit(10, 20, 100, s);
        wait_done("t6b", s);
        check("t6b_writes", wr_count, 16);
        check("t6b_queue_left", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
